// File: rtl/zube_fifo.sv
// Buffered Z80 I/O-port to Wishbone mailbox: one byte FIFO per direction,
// a status port on each side and a maskable level interrupt to the SoC.
module zube_fifo #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter int          DEPTH_LOG2     = 3,
  parameter logic [7:0]  Z80_BASE_RESET = 8'h80
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        z80_write_strobe_b,
  input  logic        z80_read_strobe_b,
  input  logic        z80_ioreq_b,
  input  logic        z80_m1,
  input  logic [7:0]  z80_address_bus,
  input  logic [7:0]  z80_data_bus_in,
  output logic [7:0]  z80_data_bus_out,
  output logic        z80_bus_dir,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic [31:0] wb_data_out,
  output logic        irq_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [LW-1:0]         lvl_t;
  localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

  logic       rd_s1, rd_s2, rd_s3, wr_s1, wr_s2, wr_s3;
  logic [7:0] addr_s1, addr_s2, din_s1, din_s2;
  logic       rd_raw, wr_raw, rd_ev, wr_ev;

  logic [7:0] z80_base;
  logic       driven, ovf, unf;
  logic [3:0] irqen;
  logic [3:0] src;

  logic [7:0] rxf_mem [DEPTH];
  logic [7:0] txf_mem [DEPTH];
  ptr_t       rxf_wp, rxf_rp, txf_wp, txf_rp;
  lvl_t       rxf_lvl, txf_lvl;
  logic       rxf_empty, rxf_full, txf_empty, txf_full;
  logic       rxf_push, rxf_pop, txf_push, txf_pop;
  logic       ovf_set, ovf_clr, unf_set, unf_clr;

  logic        port_data, port_stat;
  logic        z80_rd_data, z80_rd_stat, z80_wr_data, z80_wr_stat;
  logic [31:0] off;
  logic        sel_base, sel_data, sel_stat, sel_irqen, sel_irqstat;
  logic        hit, wb_wr, wb_rd;
  logic [31:0] status_word, rdata;
  logic        unused;

  assign rd_raw = z80_m1 & ~z80_ioreq_b & ~z80_read_strobe_b;
  assign wr_raw = z80_m1 & ~z80_ioreq_b & ~z80_write_strobe_b;
  // One event per strobe assertion: rising edge of the synchronised request.
  assign rd_ev  = rd_s2 & ~rd_s3;
  assign wr_ev  = wr_s2 & ~wr_s3;

  assign port_data   = (addr_s2 == z80_base);
  assign port_stat   = (addr_s2 == (z80_base + 8'd1));
  assign z80_rd_data = rd_ev & port_data;
  assign z80_rd_stat = rd_ev & port_stat;
  assign z80_wr_data = wr_ev & port_data;
  assign z80_wr_stat = wr_ev & port_stat;

  // Wishbone classic: the master holds cyc/stb/addr/data until it sees ack;
  // ack is a single-cycle pulse and masks hit so each transfer acts once.
  assign off         = wb_addr_in - BASE_ADDRESS;
  assign sel_base    = (off == 32'd0);
  assign sel_data    = (off == 32'd4);
  assign sel_stat    = (off == 32'd8);
  assign sel_irqen   = (off == 32'd12);
  assign sel_irqstat = (off == 32'd16);
  assign hit = wb_cyc_in & wb_stb_in & ~wb_ack_out &
               (sel_base | sel_data | sel_stat | sel_irqen | sel_irqstat);
  assign wb_wr = hit & wb_we_in;
  assign wb_rd = hit & ~wb_we_in;

  assign rxf_empty = (rxf_lvl == '0);
  assign rxf_full  = (rxf_lvl == FULL_LVL);
  assign txf_empty = (txf_lvl == '0);
  assign txf_full  = (txf_lvl == FULL_LVL);

  // A simultaneous pop frees the slot, so a push at full still lands.
  assign rxf_pop  = wb_rd & sel_data & ~rxf_empty;
  assign rxf_push = z80_wr_data & (~rxf_full | rxf_pop);
  assign txf_pop  = z80_rd_data & ~txf_empty;
  assign txf_push = wb_wr & sel_data & (~txf_full | txf_pop);

  assign ovf_set = z80_wr_data & rxf_full & ~rxf_pop;
  assign unf_set = z80_rd_data & txf_empty;
  assign ovf_clr = (z80_wr_stat & din_s2[2]) | (wb_wr & sel_irqstat & wb_data_in[2]);
  assign unf_clr = (z80_wr_stat & din_s2[3]) | (wb_wr & sel_irqstat & wb_data_in[3]);

  assign src         = {unf, ovf, txf_empty, ~rxf_empty};
  assign status_word = {12'b0, unf, ovf, txf_full, rxf_full, 8'(txf_lvl), 8'(rxf_lvl)};
  assign z80_bus_dir = driven & ~z80_read_strobe_b;
  assign unused      = ^wb_data_in[31:8];

  always_comb begin
    rdata = 32'b0;
    if (sel_base)         rdata = {24'b0, z80_base};
    else if (sel_data)    rdata = rxf_empty ? 32'b0 : {23'b0, 1'b1, rxf_mem[rxf_rp]};
    else if (sel_stat)    rdata = status_word;
    else if (sel_irqen)   rdata = {28'b0, irqen};
    else if (sel_irqstat) rdata = {28'b0, src};
  end

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem[rxf_wp] <= din_s2;
    if (txf_push) txf_mem[txf_wp] <= wb_data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rd_s1 <= 1'b0; rd_s2 <= 1'b0; rd_s3 <= 1'b0;
      wr_s1 <= 1'b0; wr_s2 <= 1'b0; wr_s3 <= 1'b0;
      addr_s1 <= 8'h00; addr_s2 <= 8'h00; din_s1 <= 8'h00; din_s2 <= 8'h00;
      z80_base <= Z80_BASE_RESET;
      driven <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      irqen <= 4'h0;
      rxf_wp <= '0; rxf_rp <= '0; rxf_lvl <= '0;
      txf_wp <= '0; txf_rp <= '0; txf_lvl <= '0;
      z80_data_bus_out <= 8'h00;
      wb_ack_out <= 1'b0;
      wb_data_out <= 32'h0;
      irq_out <= 1'b0;
    end else begin
      rd_s1 <= rd_raw; rd_s2 <= rd_s1; rd_s3 <= rd_s2;
      wr_s1 <= wr_raw; wr_s2 <= wr_s1; wr_s3 <= wr_s2;
      addr_s1 <= z80_address_bus; addr_s2 <= addr_s1;
      din_s1  <= z80_data_bus_in; din_s2  <= din_s1;

      // Data is held for the whole strobe; release once the request has gone.
      if (rd_ev & (port_data | port_stat)) driven <= 1'b1;
      else if (!rd_s2)                     driven <= 1'b0;

      if (z80_rd_data)      z80_data_bus_out <= txf_empty ? 8'hFF : txf_mem[txf_rp];
      else if (z80_rd_stat) z80_data_bus_out <= {4'h0, unf, ovf, ~rxf_full, ~txf_empty};

      if (wb_wr & sel_base)  z80_base <= wb_data_in[7:0];
      if (wb_wr & sel_irqen) irqen    <= wb_data_in[3:0];

      ovf <= ovf_set | (ovf & ~ovf_clr);
      unf <= unf_set | (unf & ~unf_clr);

      if (rxf_push) rxf_wp <= rxf_wp + ptr_t'(1);
      if (rxf_pop)  rxf_rp <= rxf_rp + ptr_t'(1);
      if (rxf_push & ~rxf_pop)      rxf_lvl <= rxf_lvl + lvl_t'(1);
      else if (rxf_pop & ~rxf_push) rxf_lvl <= rxf_lvl - lvl_t'(1);

      if (txf_push) txf_wp <= txf_wp + ptr_t'(1);
      if (txf_pop)  txf_rp <= txf_rp + ptr_t'(1);
      if (txf_push & ~txf_pop)      txf_lvl <= txf_lvl + lvl_t'(1);
      else if (txf_pop & ~txf_push) txf_lvl <= txf_lvl - lvl_t'(1);

      wb_ack_out <= hit;
      if (hit) wb_data_out <= rdata;
      irq_out <= |(irqen & src);
    end
  end
endmodule

// File: tb/tb_zube_fifo.sv
// Directed bench for zube_fifo: a register vector table plus hand-written
// Z80/Wishbone sequences for FIFO boundaries, interrupts and mid-cycle reset.
`timescale 1ns/1ps
module tb_zube_fifo;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        z80_write_strobe_b = 1'b1;
  logic        z80_read_strobe_b = 1'b1;
  logic        z80_ioreq_b = 1'b1;
  logic        z80_m1 = 1'b1;
  logic [7:0]  z80_address_bus = 8'h00;
  logic [7:0]  z80_data_bus_in = 8'h00;
  logic [7:0]  z80_data_bus_out;
  logic        z80_bus_dir;
  logic        wb_cyc_in = 1'b0;
  logic        wb_stb_in = 1'b0;
  logic        wb_we_in = 1'b0;
  logic [31:0] wb_addr_in = 32'h0;
  logic [31:0] wb_data_in = 32'h0;
  logic        wb_ack_out;
  logic [31:0] wb_data_out;
  logic        irq_out;

  int tests = 0;
  int failed = 0;

  zube_fifo #(.BASE_ADDRESS(BASE), .DEPTH_LOG2(3), .Z80_BASE_RESET(8'h80)) dut (
    .clk(clk), .reset_b(reset_b),
    .z80_write_strobe_b(z80_write_strobe_b), .z80_read_strobe_b(z80_read_strobe_b),
    .z80_ioreq_b(z80_ioreq_b), .z80_m1(z80_m1),
    .z80_address_bus(z80_address_bus), .z80_data_bus_in(z80_data_bus_in),
    .z80_data_bus_out(z80_data_bus_out), .z80_bus_dir(z80_bus_dir),
    .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
    .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .wb_ack_out(wb_ack_out), .wb_data_out(wb_data_out), .irq_out(irq_out)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic acked);
    @(negedge clk);
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = we;
    wb_addr_in = addr; wb_data_in = wdata;
    acked = 1'b0; rdata = 32'h0;
    for (int i = 0; i < 16 && !acked; i++) begin
      @(negedge clk);
      if (wb_ack_out) begin acked = 1'b1; rdata = wb_data_out; end
    end
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    logic [31:0] d; logic a;
    wb_xfer(1'b0, BASE + 32'(off), 32'h0, d, a);
    if (!a) begin
      tests++; failed++;
      $display("FAIL %s: no ack, expected data 0x%08h", name, exp);
    end else check(name, d, exp);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] data);
    logic [31:0] d; logic a;
    wb_xfer(1'b1, BASE + 32'(off), data, d, a);
    if (!a) begin
      tests++; failed++;
      $display("FAIL wb_write_ack: no ack at offset 0x%02h, expected ack", off);
    end
  endtask

  task automatic z80_write(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk);
    z80_address_bus = port; z80_data_bus_in = data;
    z80_ioreq_b = 1'b0; z80_write_strobe_b = 1'b0;
    repeat (4) @(negedge clk);
    z80_write_strobe_b = 1'b1; z80_ioreq_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic z80_read(input logic [7:0] port, output logic [7:0] data,
                          output logic dir, output logic dir_after);
    @(negedge clk);
    z80_address_bus = port; z80_ioreq_b = 1'b0; z80_read_strobe_b = 1'b0;
    repeat (3) @(negedge clk);
    data = z80_data_bus_out; dir = z80_bus_dir;
    z80_read_strobe_b = 1'b1; z80_ioreq_b = 1'b1;
    #1 dir_after = z80_bus_dir;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  zd;
    logic        zdir, zdir_after, acked;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0080};
    vecs[1]  = '{1'b0, 8'h08, 32'h0,         32'h0000_0000};
    vecs[2]  = '{1'b0, 8'h0C, 32'h0,         32'h0000_0000};
    vecs[3]  = '{1'b0, 8'h10, 32'h0,         32'h0000_0002};
    vecs[4]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0000};
    vecs[5]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, 8'h0C, 32'h0,         32'h0000_000F};
    vecs[7]  = '{1'b1, 8'h0C, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 8'h00, 32'h1234_5655, 32'h0};
    vecs[9]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0055};
    vecs[10] = '{1'b1, 8'h00, 32'h0000_0080, 32'h0};
    vecs[11] = '{1'b0, 8'h00, 32'h0,         32'h0000_0080};

    // Reset
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    check("rst_irq", 32'(irq_out), 32'h0);
    check("rst_ack", 32'(wb_ack_out), 32'h0);
    check("rst_wbdata", wb_data_out, 32'h0);
    check("rst_z80data", 32'(z80_data_bus_out), 32'h0);
    check("rst_busdir", 32'(z80_bus_dir), 32'h0);

    // Register vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) wb_write(vecs[i].off, vecs[i].wdata);
      else wb_read(vecs[i].off, vecs[i].exp, $sformatf("vec[%0d]", i));
    end
    check("irq_after_table", 32'(irq_out), 32'h0);
    wb_xfer(1'b0, BASE + 32'h20, 32'h0, rd, acked);
    check("unmapped_noack", 32'(acked), 32'h0);

    // Z80 to SoC basic transfer
    z80_write(8'h80, 8'h11);
    z80_write(8'h80, 8'h22);
    wb_read(8'h04, 32'h111, "rx_pop0");
    wb_read(8'h04, 32'h122, "rx_pop1");
    wb_read(8'h04, 32'h000, "rx_pop_empty");

    // RXF overflow with pointer wrap
    for (int i = 0; i < 9; i++) z80_write(8'h80, 8'(8'h30 + i));
    wb_read(8'h08, 32'h0005_0008, "rx_full_status");
    for (int i = 0; i < 8; i++) wb_read(8'h04, 32'h100 | (32'h30 + i), $sformatf("rx_wrap[%0d]", i));
    wb_read(8'h10, 32'h6, "irqstat_ovf");
    wb_write(8'h10, 32'h4);
    wb_read(8'h08, 32'h0, "ovf_cleared");

    // Interrupt on RXF not empty, falling one cycle after the popping ack
    wb_write(8'h0C, 32'h1);
    check("irq_idle", 32'(irq_out), 32'h0);
    z80_write(8'h80, 8'h77);
    check("irq_rise", 32'(irq_out), 32'h1);
    wb_xfer(1'b0, BASE + 32'h4, 32'h0, rd, acked);
    check("irq_pop_data", rd, 32'h177);
    check("irq_at_ack", 32'(irq_out), 32'h1);
    @(negedge clk);
    check("irq_fall", 32'(irq_out), 32'h0);
    wb_write(8'h0C, 32'h0);

    // Fill RXF exactly, then SoC to Z80 path and underflow
    for (int i = 0; i < 8; i++) z80_write(8'h80, 8'(8'h50 + i));
    wb_read(8'h08, 32'h0001_0008, "rx_exact_full");
    wb_write(8'h04, 32'hFFFF_FFA5);
    z80_read(8'h80, zd, zdir, zdir_after);
    check("tx_byte", 32'(zd), 32'hA5);
    check("tx_busdir", 32'(zdir), 32'h1);
    check("tx_busdir_release", 32'(zdir_after), 32'h0);
    z80_read(8'h80, zd, zdir, zdir_after);
    check("tx_underflow", 32'(zd), 32'hFF);
    z80_read(8'h81, zd, zdir, zdir_after);
    check("z80_status", 32'(zd), 32'h08);
    z80_read(8'h42, zd, zdir, zdir_after);
    check("other_port_nodrive", 32'(zdir), 32'h0);

    // Z80 push and WB pop on the same edge at RXF full
    @(negedge clk);
    z80_address_bus = 8'h80; z80_data_bus_in = 8'h99;
    z80_ioreq_b = 1'b0; z80_write_strobe_b = 1'b0;
    repeat (2) @(negedge clk);
    wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b0; wb_addr_in = BASE + 32'h4;
    @(negedge clk);
    check("same_cycle_ack", 32'(wb_ack_out), 32'h1);
    check("same_cycle_data", wb_data_out, 32'h150);
    wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
    z80_write_strobe_b = 1'b1; z80_ioreq_b = 1'b1;
    repeat (4) @(negedge clk);
    wb_read(8'h08, 32'h0009_0008, "same_cycle_status");
    z80_write(8'h81, 8'h08);
    wb_read(8'h08, 32'h0001_0008, "unf_cleared");
    for (int i = 1; i < 8; i++) wb_read(8'h04, 32'h100 | (32'h50 + i), $sformatf("rx_drain[%0d]", i));
    wb_read(8'h04, 32'h199, "rx_drain_last");

    // TXF full: the ninth byte is dropped silently
    for (int i = 0; i < 9; i++) wb_write(8'h04, 32'hC0 + i);
    wb_read(8'h08, 32'h0002_0800, "tx_full_status");
    for (int i = 0; i < 8; i++) begin
      z80_read(8'h80, zd, zdir, zdir_after);
      check($sformatf("tx_order[%0d]", i), 32'(zd), 32'hC0 + i);
    end
    wb_read(8'h10, 32'h2, "tx_drop_no_flags");

    // Reset in the middle of a Z80 read
    wb_write(8'h04, 32'h3C);
    z80_write(8'h80, 8'h12);
    @(negedge clk);
    z80_address_bus = 8'h80; z80_ioreq_b = 1'b0; z80_read_strobe_b = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busdir", 32'(z80_bus_dir), 32'h1);
    check("pre_rst_data", 32'(z80_data_bus_out), 32'h3C);
    reset_b = 1'b0;
    @(negedge clk);
    check("mid_rst_busdir", 32'(z80_bus_dir), 32'h0);
    check("mid_rst_data", 32'(z80_data_bus_out), 32'h0);
    reset_b = 1'b1; z80_read_strobe_b = 1'b1; z80_ioreq_b = 1'b1;
    repeat (4) @(negedge clk);
    wb_read(8'h08, 32'h0, "post_rst_levels");
    wb_read(8'h10, 32'h2, "post_rst_irqstat");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
